// File: rtl/regfile_write_queue_pkg.sv
// rtl/regfile_write_queue_pkg.sv - shared widths and write-request type for the register file write queue
package regfile_write_queue_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // One pending register write: target address and data
    typedef struct packed {
        logic [ADDR_W-1:0] adrx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_fwd_select.sv
// rtl/regfile_fwd_select.sv - youngest-match forwarding select for one register file read port
module regfile_fwd_select
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
)
(
    input  logic [ADDR_W-1:0] rd_adrx,
    input  wr_req_t           entries [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    input  logic [PTR_W-1:0]  head,
    input  logic [PTR_W-1:0]  tail,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] rd_data
);

    // Scan from the youngest entry (tail-1) back to the oldest (head); the first hit wins
    always_comb begin : scan
        logic [PTR_W-1:0] idx;
        logic             found;
        logic             done;
        rd_data = rf_data;
        idx     = tail;
        found   = 1'b0;
        done    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = idx - PTR_W'(1);
            if (!found && !done && valid[idx] && (entries[idx].adrx == rd_adrx)) begin
                rd_data = entries[idx].data;
                found   = 1'b1;
            end
            if (idx == head) begin
                done = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order write buffer in front of the register file with read forwarding
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic [ADDR_W-1:0]       reqAdrx,
    input  logic [DATA_W-1:0]       reqData,
    input  logic                    drainEn,
    output logic [ADDR_W-1:0]       writeAdrx,
    output logic [DATA_W-1:0]       writeData,
    output logic                    writeEn,
    input  logic [ADDR_W-1:0]       rdAdrx0,
    input  logic [ADDR_W-1:0]       rdAdrx1,
    input  logic [DATA_W-1:0]       rfData0,
    input  logic [DATA_W-1:0]       rfData1,
    output logic [DATA_W-1:0]       rdData0,
    output logic [DATA_W-1:0]       rdData1,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_req_t          entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    // Ready depends only on occupancy so a full queue never takes a request, even alongside a pop
    assign reqReady  = (count != CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign writeEn   = !empty && drainEn;
    assign writeAdrx = entries[head].adrx;
    assign writeData = entries[head].data;
    assign push      = reqValid && reqReady;
    assign pop       = writeEn;

    // Pointers, occupancy and per-entry valid bits; reset discards pending writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; meaning is carried by the valid bits so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= {reqAdrx, reqData};
        end
    end

    regfile_fwd_select #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd0 (
        .rd_adrx (rdAdrx0),
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .tail    (tail),
        .rf_data (rfData0),
        .rd_data (rdData0)
    );

    regfile_fwd_select #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fwd1 (
        .rd_adrx (rdAdrx1),
        .entries (entries),
        .valid   (valid),
        .head    (head),
        .tail    (tail),
        .rf_data (rfData1),
        .rd_data (rdData1)
    );

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - self-checking bench for regfile_write_queue
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [4:0]  reqAdrx;
    logic [31:0] reqData;
    logic        drainEn;
    logic [4:0]  writeAdrx;
    logic [31:0] writeData;
    logic        writeEn;
    logic [4:0]  rdAdrx0;
    logic [4:0]  rdAdrx1;
    logic [31:0] rfData0;
    logic [31:0] rfData1;
    logic [31:0] rdData0;
    logic [31:0] rdData1;
    logic [2:0]  count;
    logic        empty;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];
    int          n_tests;
    int          n_fail;

    regfile_write_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqAdrx   (reqAdrx),
        .reqData   (reqData),
        .drainEn   (drainEn),
        .writeAdrx (writeAdrx),
        .writeData (writeData),
        .writeEn   (writeEn),
        .rdAdrx0   (rdAdrx0),
        .rdAdrx1   (rdAdrx1),
        .rfData0   (rfData0),
        .rfData1   (rfData1),
        .rdData0   (rdData0),
        .rdData1   (rdData1),
        .count     (count),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file behind the queue: captures whatever the DUT writes
    always @(posedge clk) begin
        if (writeEn) dut_rf[writeAdrx] <= writeData;
    end
    assign rfData0 = dut_rf[rdAdrx0];
    assign rfData1 = dut_rf[rdAdrx1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Newest value a reader should see: youngest queued write, else the register file
    function automatic logic [31:0] fwd(input logic [4:0] ad);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ad) return q[i].d;
        end
        return model_rf[ad];
    endfunction

    // One cycle: drive inputs, check outputs against the model, clock, update the model
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic dr, input logic [4:0] r0, input logic [4:0] r1);
        logic do_push;
        logic do_pop;
        ent_t e;
        reqValid = v;
        reqAdrx  = a;
        reqData  = d;
        drainEn  = dr;
        rdAdrx0  = r0;
        rdAdrx1  = r1;
        #1;
        do_pop  = dr && (q.size() != 0);
        do_push = v && (q.size() != DEPTH);
        check("reqReady", reqReady, q.size() != DEPTH);
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("writeEn", writeEn, do_pop);
        if (do_pop) begin
            check("writeAdrx", writeAdrx, q[0].a);
            check("writeData", writeData, q[0].d);
        end
        check("rdData0", rdData0, fwd(r0));
        check("rdData1", rdData1, fwd(r1));
        @(posedge clk);
        if (do_pop) begin
            model_rf[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (do_push) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain_all();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd1);
        end
        check("drain_all_empty", empty, 1'b1);
    endtask

    function automatic logic [4:0] rnd_adrx();
        logic [4:0] r;
        r = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        return r;
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        reqValid = 1'b0;
        reqAdrx  = '0;
        reqData  = '0;
        drainEn  = 1'b1;
        rdAdrx0  = '0;
        rdAdrx1  = '0;
        for (int i = 0; i < 32; i++) begin
            dut_rf[i]   = 32'h5A00_0000 + 32'(i * 32'h0101);
            model_rf[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
        end
        dut_rf[7]   = 32'hAA;
        model_rf[7] = 32'hAA;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_writeEn", writeEn, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_empty", empty, 1'b1);
        rst = 1'b1;
        #1;
        check("rel_reqReady", reqReady, 1'b1);
        @(negedge clk);

        // Single write appears one cycle after acceptance
        step(1'b1, 5'd5, 32'hFFFF000F, 1'b1, 5'd5, 5'd6);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);

        // Fill while stalled, hold a fifth request, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i), $urandom, 1'b0, 5'(i), 5'd2);
        step(1'b1, 5'd9, 32'hC0FFEE09, 1'b0, 5'd9, 5'd3);
        check("full_count", count, 3'd4);
        for (int i = 0; i < 6; i++) step(i == 0, 5'd9, 32'hC0FFEE09, 1'b1, 5'd9, 5'd0);
        drain_all();

        // Youngest match forwarding through partial drain
        step(1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
        check("fwd_youngest", rdData0, 32'h22);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd7);
        check("fwd_after_drain", rdData0, 32'h22);

        // Simultaneous push and pop across pointer wrap
        step(1'b1, 5'd10, $urandom, 1'b0, 5'd10, 5'd11);
        step(1'b1, 5'd11, $urandom, 1'b0, 5'd10, 5'd11);
        for (int i = 0; i < 10; i++) step(1'b1, 5'(12 + i), $urandom, 1'b1, 5'(12 + i), 5'(11 + i));
        check("pushpop_count", count, 3'd2);
        drain_all();

        // Upper-bit-only address difference must not forward
        step(1'b1, 5'd3, 32'h3333_0003, 1'b0, 5'd3, 5'd19);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd19);
        drain_all();

        // Reset in the middle of a drain discards pending writes
        step(1'b1, 5'd20, 32'hDEAD0020, 1'b0, 5'd20, 5'd21);
        step(1'b1, 5'd21, 32'hDEAD0021, 1'b0, 5'd20, 5'd21);
        step(1'b1, 5'd22, 32'hDEAD0022, 1'b0, 5'd20, 5'd21);
        reqValid = 1'b0;
        drainEn  = 1'b1;
        #1;
        check("middrain_writeEn", writeEn, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_writeEn", writeEn, 1'b0);
        check("arst_count", count, 3'd0);
        check("arst_empty", empty, 1'b1);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_reqReady", reqReady, 1'b1);
        for (int i = 20; i < 23; i++) check("arst_no_write", dut_rf[i], model_rf[i]);
        @(negedge clk);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_adrx(), $urandom, $urandom_range(0, 2) != 0,
                 rnd_adrx(), rnd_adrx());
        end
        drain_all();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) check("final_rf", dut_rf[i], model_rf[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
Write-side buffer placed directly upstream of the 32x32 register file. It accepts write requests on a valid/ready handshake and holds them in a small in-order FIFO. It drains at most one entry per cycle into the register file's single write port (writeAdrx/writeData/writeEn). Both read ports are forwarded, so a reader always sees the newest value, including writes still sitting in the queue.

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width

Ports:
clk  in  1  system clock; register file samples writes on posedge
rst  in  1  asynchronous, active-low reset
reqValid  in  1  write request present
reqReady  out  1  queue can accept a request this cycle
reqAdrx  in  ADDR_W  request target register
reqData  in  DATA_W  request write data
drainEn  in  1  permits draining to the register file; 0 stalls the queue
writeAdrx  out  ADDR_W  to register file write address
writeData  out  DATA_W  to register file write data
writeEn  out  1  to register file write enable
rdAdrx0  in  ADDR_W  read port 0 address; also routed to the register file
rdAdrx1  in  ADDR_W  read port 1 address; also routed to the register file
rfData0  in  DATA_W  raw register file read data, port 0
rfData1  in  DATA_W  raw register file read data, port 1
rdData0  out  DATA_W  forwarded read data, port 0
rdData1  out  DATA_W  forwarded read data, port 1
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count==0

Behaviour:
- Reset (rst low, asynchronous): count=0, head=tail=0, all entry valid bits cleared, so writeEn=0 and empty=1. Takes effect immediately, even mid-drain. Pending writes are discarded and not written. After release: reqReady=1.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a separate counter.
- Accept (push): on posedge when reqValid && reqReady. Entry {reqAdrx, reqData} is written at tail, then tail+1.
- reqReady = (count != DEPTH). It is registered-state only, with no combinational path from drainEn or reqValid. When full, a request is held off even if a pop happens in the same cycle.
- Drain (pop): writeEn = !empty && drainEn. writeAdrx/writeData = entry at head, combinational from storage. On a posedge with writeEn=1, the register file captures the entry and head advances by 1.
- Latency: an accepted request drives writeEn in the next cycle at the earliest. A queue that is empty stays empty in the cycle of a push (no bypass to the write port).
- Simultaneous push and pop: count unchanged; both pointers advance.
- drainEn=0: contents held. Pushes continue until full.
- Ordering: strictly FIFO. Duplicate addresses are all written, in order.
- Forwarding, per read port p, combinational:
  - Compare rdAdrxp against every valid entry.
  - If matches exist, rdDatap = data of the youngest matching entry (closest to tail).
  - Otherwise rdDatap = rfDatap.
  - The head entry being written this cycle is still forwarded, because the register file updates only at the edge.
  - The request being pushed this cycle is not forwarded; it becomes visible next cycle.
- All 32 addresses, including 0, are ordinary writable registers. There is no hardwired zero.
- Widths: all comparisons use the full ADDR_W. count never exceeds DEPTH; no overflow or underflow is possible given the handshake rules.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_REGS=32, and a write-request struct typedef {adrx, data}.
- One sub-module: regfile_fwd_select. Inputs are a read address, the entry array, per-entry valid bits and the head/tail pointers. It does the youngest-match priority select and the fallback to rfData. It is instantiated twice, once per read port.

Test Plan:
- Reset then idle: rst low mid-operation with 3 entries queued -> writeEn=0 and count=0 immediately; after release reqReady=1 and empty=1; no register is written.
- Single write: push {5, 32'hFFFF000F} with drainEn=1 -> writeEn=1, writeAdrx=5, writeData=FFFF000F exactly one cycle later; then empty=1.
- Fill/stall: drainEn=0, push addresses 0..3 -> count=4 and reqReady=0; a 5th request is held; set drainEn=1 -> writes issue in order 0,1,2,3 on consecutive cycles and reqReady rises after the first pop.
- Forward youngest: drainEn=0, push {7,0x11} then {7,0x22}; rdAdrx0=7 with rfData0=0xAA -> rdData0=0x22; drain one entry -> rdData0 still 0x22; drain both -> rdData0=rfData0.
- Simultaneous push/pop: count=2 with drainEn=1, push every cycle for 10 cycles -> count stays 2; the write sequence matches push order across pointer wrap-around.
- No-match passthrough: queue holds address 3; rdAdrx1=19 (differs only in the upper bit) -> rdData1=rfData1.
